// File: rtl/vn_page_load_ctrl.sv
// Loads one iteration's 64 IB pages from the IB-ROM pair into IB-RAM.
// state | meaning
// IDLE  | waiting for load_start; rejects out-of-range iterations
// FETCH | issuing ROM reads, one page per cycle, pages 0..63
// DRAIN | ROM reads done, waiting for the last RAM write
// DONE  | one-cycle completion pulse, then back to IDLE
module vn_page_load_ctrl #(
  parameter int ROM_RD_BW    = 8,
  parameter int ROM_ADDR_BW  = 11,
  parameter int PAGE_ADDR_BW = 6,
  parameter int ITER_ADDR_BW = 5,
  parameter int ROM_LAT      = 2
) (
  input  logic                    write_clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [ITER_ADDR_BW:0]   load_iter,
  input  logic [ROM_RD_BW-1:0]    rom_dinA,
  input  logic [ROM_RD_BW-1:0]    rom_dinB,
  output logic                    rom_en,
  output logic [ROM_ADDR_BW-1:0]  rom_read_addr,
  output logic                    iter_switch,
  output logic                    ram_we,
  output logic [PAGE_ADDR_BW-1:0] ram_waddr,
  output logic [ROM_RD_BW-1:0]    ram_dinA,
  output logic [ROM_RD_BW-1:0]    ram_dinB,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ITER_ADDR_BW:0]   ITER_PER_ROM = (ITER_ADDR_BW+1)'(25);
  localparam logic [ITER_ADDR_BW:0]   ITER_MAX     = (ITER_ADDR_BW+1)'(49);
  localparam logic [PAGE_ADDR_BW-1:0] PAGE_LAST    = '1;

  state_t                    state_q, state_d;
  logic [PAGE_ADDR_BW-1:0]   page_q;
  logic [PAGE_ADDR_BW-1:0]   page_inc;
  logic [ITER_ADDR_BW-1:0]   iter_local_q;
  logic [ITER_ADDR_BW-1:0]   iter_local_d;
  logic [ROM_LAT-1:0]        vld_q;
  logic                      accept;
  logic                      reject;
  logic                      last_page;

  assign page_inc  = page_q + 1'b1;
  assign last_page = (page_q == PAGE_LAST);

  // Iterations 25..49 live in the second ROM group at the same local offsets.
  always_comb begin
    iter_local_d = ITER_ADDR_BW'(load_iter);
    if (load_iter >= ITER_PER_ROM)
      iter_local_d = ITER_ADDR_BW'(load_iter - ITER_PER_ROM);
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    busy      = (state_q != IDLE);
    load_done = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_iter <= ITER_MAX) begin
            accept  = 1'b1;
            state_d = FETCH;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      FETCH:   if (last_page) state_d = DRAIN;
      DRAIN:   if (ram_we && (ram_waddr == PAGE_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      page_q        <= '0;
      iter_local_q  <= '0;
      rom_en        <= 1'b0;
      rom_read_addr <= '0;
      iter_switch   <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      load_err <= reject;
      if (accept) begin
        iter_switch   <= (load_iter >= ITER_PER_ROM);
        iter_local_q  <= iter_local_d;
        page_q        <= '0;
        rom_en        <= 1'b1;
        rom_read_addr <= ROM_ADDR_BW'({iter_local_d, {PAGE_ADDR_BW{1'b0}}});
      end else if (state_q == FETCH) begin
        if (last_page) begin
          // Counter wraps to 0 but no read is issued for it.
          rom_en <= 1'b0;
          page_q <= '0;
        end else begin
          page_q        <= page_inc;
          rom_read_addr <= ROM_ADDR_BW'({iter_local_q, page_inc});
        end
      end
    end
  end

  // vld_q[i] marks that the ROM address from i+1 cycles ago was a real read.
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rom_en;
      for (int i = 1; i < ROM_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_dinA  <= '0;
      ram_dinB  <= '0;
    end else begin
      ram_we <= vld_q[ROM_LAT-1];
      if (vld_q[ROM_LAT-1]) begin
        ram_dinA <= rom_dinA;
        ram_dinB <= rom_dinB;
      end
      if (ram_we) ram_waddr <= ram_waddr + 1'b1;
      if (accept) ram_waddr <= '0;
    end
  end

endmodule

// File: tb/tb_vn_page_load_ctrl.sv
// Randomized self-checking bench for vn_page_load_ctrl against a cycle-timeline
// reference model and a two-cycle-latency ROM stub.
module tb_vn_page_load_ctrl;

  logic        write_clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [5:0]  load_iter = '0;
  logic [7:0]  rom_dinA = '0;
  logic [7:0]  rom_dinB = '0;
  logic        rom_en;
  logic [10:0] rom_read_addr;
  logic        iter_switch;
  logic        ram_we;
  logic [5:0]  ram_waddr;
  logic [7:0]  ram_dinA;
  logic [7:0]  ram_dinB;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad = 0;
  int seed_a;
  int seed_b;
  logic [10:0] rom_a1 = '0;
  logic        rom_s1 = 1'b0;

  always #5 write_clk = ~write_clk;

  vn_page_load_ctrl dut (
    .write_clk     (write_clk),
    .rst           (rst),
    .load_start    (load_start),
    .load_iter     (load_iter),
    .rom_dinA      (rom_dinA),
    .rom_dinB      (rom_dinB),
    .rom_en        (rom_en),
    .rom_read_addr (rom_read_addr),
    .iter_switch   (iter_switch),
    .ram_we        (ram_we),
    .ram_waddr     (ram_waddr),
    .ram_dinA      (ram_dinA),
    .ram_dinB      (ram_dinB),
    .busy          (busy),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  function automatic logic [7:0] rom_val(input int addr, input bit sw, input int seed);
    int v;
    v = addr * 37 + seed + (sw ? 101 : 0);
    v = v ^ (addr >> 3);
    return v[7:0];
  endfunction

  // ROM pair: data for the address seen in cycle t appears in cycle t+2.
  always @(posedge write_clk) begin
    rom_a1   <= rom_read_addr;
    rom_s1   <= iter_switch;
    rom_dinA <= rom_val(int'(rom_a1), rom_s1, seed_a);
    rom_dinB <= rom_val(int'(rom_a1), rom_s1, seed_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rom_en"},    32'(rom_en), 0);
    chk({tag, ".rom_addr"},  32'(rom_read_addr), 0);
    chk({tag, ".iter_sw"},   32'(iter_switch), 0);
    chk({tag, ".ram_we"},    32'(ram_we), 0);
    chk({tag, ".ram_waddr"}, 32'(ram_waddr), 0);
    chk({tag, ".dinA"},      32'(ram_dinA), 0);
    chk({tag, ".dinB"},      32'(ram_dinB), 0);
    chk({tag, ".busy"},      32'(busy), 0);
    chk({tag, ".done"},      32'(load_done), 0);
    chk({tag, ".err"},       32'(load_err), 0);
  endtask

  // Expected behaviour in cycle k+j of a load accepted at edge k.
  task automatic check_cycle(input int j, input int base, input bit sw, inout int writes);
    bit we_exp;
    we_exp = (j >= 4) && (j <= 67);
    chk("busy",     32'(busy), 1);
    chk("done",     32'(load_done), 32'(j == 68));
    chk("err",      32'(load_err), 0);
    chk("iter_sw",  32'(iter_switch), 32'(sw));
    chk("rom_en",   32'(rom_en), 32'(j <= 64));
    chk("rom_addr", 32'(rom_read_addr), base + ((j <= 64) ? j - 1 : 63));
    chk("ram_we",   32'(ram_we), 32'(we_exp));
    if (ram_we === 1'b1) writes++;
    if (we_exp) begin
      chk("waddr", 32'(ram_waddr), j - 4);
      chk("dinA",  32'(ram_dinA), 32'(rom_val(base + j - 4, sw, seed_a)));
      chk("dinB",  32'(ram_dinB), 32'(rom_val(base + j - 4, sw, seed_b)));
    end
    if (j == 68) begin
      chk("dinA_hold",  32'(ram_dinA), 32'(rom_val(base + 63, sw, seed_a)));
      chk("waddr_wrap", 32'(ram_waddr), 0);
    end
  endtask

  // Called and returns on a negedge; abort_at>0 stops after checking that page.
  task automatic run_load(input int iter, input bit noise, input int abort_at);
    int  base;
    int  writes;
    bit  sw;
    writes = 0;
    sw   = (iter >= 25);
    base = (sw ? iter - 25 : iter) * 64;
    load_iter  = 6'(iter);
    load_start = 1'b1;
    @(posedge write_clk); #1;
    load_start = 1'b0;
    for (int j = 1; j <= 68; j++) begin
      @(negedge write_clk);
      check_cycle(j, base, sw, writes);
      if (abort_at != 0 && j == abort_at + 1) return;
      if (noise && (j == 11 || j == 64 || j == 68)) begin
        load_start = 1'b1;
        load_iter  = 6'($urandom_range(0, 49));
      end
      @(posedge write_clk); #1;
      load_start = 1'b0;
    end
    chk("write_count", 32'(writes), 64);
    @(negedge write_clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(load_done), 0);
  endtask

  task automatic run_reject(input int iter);
    load_iter  = 6'(iter);
    load_start = 1'b1;
    @(posedge write_clk); #1;
    load_start = 1'b0;
    @(negedge write_clk);
    chk("rej_err",    32'(load_err), 1);
    chk("rej_busy",   32'(busy), 0);
    chk("rej_rom_en", 32'(rom_en), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge write_clk);
      chk("rej_err_off", 32'(load_err), 0);
      chk("rej_rom_en",  32'(rom_en), 0);
      chk("rej_ram_we",  32'(ram_we), 0);
      chk("rej_busy",    32'(busy), 0);
    end
  endtask

  initial begin
    seed_a = int'($urandom);
    seed_b = int'($urandom);
    #12;
    check_all_zero("reset");
    @(posedge write_clk); #1;
    rst = 1'b0;
    @(negedge write_clk);

    run_load(0, 1'b0, 0);
    run_load(30, 1'b0, 0);
    run_reject(50);
    run_reject(int'($urandom_range(51, 63)));

    // Ignored starts at pages 10, 63 and in DONE; next load one cycle after DONE.
    run_load(int'($urandom_range(0, 49)), 1'b1, 0);
    run_load(int'($urandom_range(0, 49)), 1'b0, 0);

    // Abort while page 20 is being issued.
    run_load(int'($urandom_range(0, 49)), 1'b0, 20);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge write_clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge write_clk);
      chk("post_rst_we",   32'(ram_we), 0);
      chk("post_rst_en",   32'(rom_en), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    run_load(7, 1'b0, 0);

    run_load(24, 1'b0, 0);
    run_load(25, 1'b0, 0);

    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge write_clk);
      run_load(int'($urandom_range(0, 49)), 1'(n & 1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
